// File: rtl/utopia1_phy_tx.sv
// utopia1_phy_tx: two-slot ping-pong Utopia L1 PHY transmit cell buffer with cell-level clav flow control.
// Define UTOPIA1_PHY_HEC_EN to replace byte 5 with the computed HEC.
module utopia1_phy_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       wr_soc,
    output logic       wr_rdy,
    output logic [7:0] data,
    output logic       soc,
    input  logic       en,
    output logic       clav
);
    typedef enum logic {W_IDLE, W_FILL} wst_t;
    typedef enum logic {T_IDLE, T_SEND} tst_t;
    wst_t       wst_q, wst_d;
    tst_t       tst_q, tst_d;
    logic [5:0] wr_idx_q, wr_idx_d, tx_idx_q, tx_idx_d, wr_addr;
    logic       wr_slot_q, wr_slot_d, tx_slot_q, tx_slot_d, nxt_slot;
    logic       wr_start, wr_we, done, last, go, send;
    logic [1:0] full_q, full_d, full_set, full_clr;
    logic [7:0] data_q, data_d, wr_byte;
    logic       soc_q, soc_d, clav_q, clav_d;
    logic [7:0] mem_q [2][53];

    assign wr_rdy = ~&full_q;
    assign data   = data_q;
    assign soc    = soc_q;
    assign clav   = clav_q;

    always_comb begin
        wr_start  = wr_en & wr_soc & ((wst_q == W_FILL) | wr_rdy);
        wr_we     = wr_start | (wr_en & (wst_q == W_FILL));
        wr_addr   = wr_start ? 6'd0 : wr_idx_q;
        wr_idx_d  = wr_we ? wr_addr + 6'd1 : wr_idx_q;
        done      = wr_we & (wr_addr == 6'd52);
        wst_d     = done ? W_IDLE : (wr_we ? W_FILL : wst_q);
        wr_slot_d = wr_slot_q ^ done;
        full_set  = done ? (wr_slot_q ? 2'b10 : 2'b01) : 2'b00;
    end

`ifdef UTOPIA1_PHY_HEC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) x = x[7] ? {x[6:0], 1'b0} ^ 8'h07 : {x[6:0], 1'b0};
        return x;
    endfunction

    // HEC is ready when byte 5 arrives, so it is stored in place of that byte
    always_comb begin
        crc_d   = (wr_we & (wr_addr < 6'd4)) ? crc8(wr_start ? 8'h00 : crc_q, wr_data) : crc_q;
        wr_byte = (wr_addr == 6'd4) ? crc_q ^ 8'h55 : wr_data;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) crc_q <= 8'h00;
        else     crc_q <= crc_d;
`else
    assign wr_byte = wr_data;
`endif

    // the slot after the current one is the next candidate once byte 53 is out
    always_comb begin
        last      = (tst_q == T_SEND) & (tx_idx_q == 6'd52);
        nxt_slot  = tx_slot_q ^ last;
        full_clr  = last ? (tx_slot_q ? 2'b10 : 2'b01) : 2'b00;
        go        = ((tst_q == T_IDLE) | last) & full_q[nxt_slot] & ~en;
        send      = go | ((tst_q == T_SEND) & ~last);
        tst_d     = send ? T_SEND : T_IDLE;
        tx_idx_d  = go ? 6'd0 : (send ? tx_idx_q + 6'd1 : tx_idx_q);
        tx_slot_d = nxt_slot;
        data_d    = send ? mem_q[nxt_slot][tx_idx_d] : 8'h00;
        soc_d     = go;
        full_d    = (full_q & ~full_clr) | full_set;
        clav_d    = |full_d;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wst_q     <= W_IDLE;
            tst_q     <= T_IDLE;
            wr_idx_q  <= 6'd0;
            tx_idx_q  <= 6'd0;
            wr_slot_q <= 1'b0;
            tx_slot_q <= 1'b0;
            full_q    <= 2'b00;
            data_q    <= 8'h00;
            soc_q     <= 1'b0;
            clav_q    <= 1'b0;
        end else begin
            wst_q     <= wst_d;
            tst_q     <= tst_d;
            wr_idx_q  <= wr_idx_d;
            tx_idx_q  <= tx_idx_d;
            wr_slot_q <= wr_slot_d;
            tx_slot_q <= tx_slot_d;
            full_q    <= full_d;
            data_q    <= data_d;
            soc_q     <= soc_d;
            clav_q    <= clav_d;
        end

    always_ff @(posedge clk)
        if (wr_we) mem_q[wr_slot_q][wr_addr] <= wr_byte;
endmodule

// File: tb/tb_utopia1_phy_tx.sv
// tb_utopia1_phy_tx: table-driven, hand-sequenced and randomized checks of utopia1_phy_tx
// against a cell-queue reference model.
module tb_utopia1_phy_tx;
    typedef logic [52:0][7:0] cell_t;
    typedef struct {
        logic [31:0] hdr;
        logic [7:0]  b5;
        logic [7:0]  hec;
        int          hold;
    } vec_t;

    logic       clk = 1'b0, rst, wr_en, wr_soc, en, wr_rdy, soc, clav;
    logic [7:0] wr_data, data;
    int         checks = 0, errors = 0, cyc = 0, mcnt = 0;
    bit         in_cell = 0, ren = 0;
    cell_t      exp_q[$];
    cell_t      got;
    int         soc_cyc[$];
    vec_t       tbl[4];

    always #5 clk = ~clk;

    utopia1_phy_tx dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_soc(wr_soc),
        .wr_rdy(wr_rdy), .data(data), .soc(soc), .en(en), .clav(clav)
    );

    task automatic chk(input string name, input logic [423:0] act, input logic [423:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // HEC as polynomial long division of the 32-bit header times x^8 by x^8+x^2+x+1
    function automatic logic [7:0] ref_hec(input cell_t c);
        logic [39:0] r;
        r = {c[0], c[1], c[2], c[3], 8'h00};
        for (int i = 39; i >= 8; i--) if (r[i]) r[i-:9] = r[i-:9] ^ 9'h107;
        return r[7:0] ^ 8'h55;
    endfunction

    function automatic cell_t model(input cell_t c);
        cell_t m;
        m = c;
`ifdef UTOPIA1_PHY_HEC_EN
        m[4] = ref_hec(c);
`endif
        return m;
    endfunction

    function automatic cell_t mk(input logic [31:0] hdr, input logic [7:0] b5);
        cell_t c;
        for (int i = 0; i < 53; i++) c[i] = 8'(i);
        {c[0], c[1], c[2], c[3]} = hdr;
        c[4] = b5;
        return c;
    endfunction

    function automatic cell_t rnd_cell();
        cell_t c;
        for (int i = 0; i < 53; i++) c[i] = 8'($urandom);
        return c;
    endfunction

    task automatic mon_step();
        cyc++;
        if (rst) in_cell = 0;
        if (soc) begin
            chk("soc_mid_cell", in_cell, 0);
            chk("cell_expected", exp_q.size() != 0, 1);
            in_cell = 1;
            mcnt = 1;
            got[0] = data;
            soc_cyc.push_back(cyc);
        end else if (in_cell) begin
            got[mcnt] = data;
            mcnt++;
            if (mcnt == 53) begin
                in_cell = 0;
                if (exp_q.size() != 0) begin
                    chk("cell_bytes", got, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end else chk("idle_data", data, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!wr_rdy && n < 500) begin
            tick();
            n++;
        end
        chk("wr_rdy_wait", wr_rdy, 1);
    endtask

    task automatic write_bytes(input cell_t c, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            wr_en = 1;
            wr_soc = (i == 0);
            wr_data = c[i];
            tick();
        end
        wr_en = 0;
        wr_soc = 0;
        if (push) exp_q.push_back(model(c));
    endtask

    task automatic write_cell(input cell_t c);
        wait_rdy();
        write_bytes(c, 53, 1);
    endtask

    task automatic drain();
        int n = 0;
        en = 0;
        while ((exp_q.size() != 0 || in_cell) && n < 400) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        cell_t c, p;
        logic [7:0] exp5;
        tbl[0] = '{32'h00010203, 8'h04, 8'h1D, 0};
        tbl[1] = '{32'h00000001, 8'hFF, 8'h52, 20};
        tbl[2] = '{32'h00000000, 8'hAA, 8'h55, 3};
        tbl[3] = '{32'h00000003, 8'h12, 8'h5C, 1};
        rst = 1; wr_en = 0; wr_soc = 0; wr_data = 0; en = 1;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk);
                #2;
                if (ren) en = 1'($urandom_range(0, 1));
            end
        join_none
        repeat (3) tick();
        chk("rst_data", data, 0);
        chk("rst_soc", soc, 0);
        chk("rst_clav", clav, 0);
        chk("rst_wr_rdy", wr_rdy, 1);
        rst = 0;
        tick();

        for (int k = 0; k < 4; k++) begin
            c = mk(tbl[k].hdr, tbl[k].b5);
`ifdef UTOPIA1_PHY_HEC_EN
            exp5 = tbl[k].hec;
`else
            exp5 = tbl[k].b5;
`endif
            en = (tbl[k].hold != 0);
            write_cell(c);
            chk("clav_after_write", clav, 1);
            for (int h = 0; h < tbl[k].hold; h++) begin
                @(negedge clk);
                chk("hold_soc", soc, 0);
                chk("hold_clav", clav, 1);
            end
            if (tbl[k].hold != 0) tick();
            en = 0;
            @(negedge clk);
            chk("pre_soc", soc, 0);
            @(negedge clk);
            chk("first_soc", soc, 1);
            chk("byte1", data, tbl[k].hdr[31:24]);
            repeat (4) @(negedge clk);
            chk("byte5", data, exp5);
            tick();
            drain();
        end

        // two cells back-to-back, third refused while both slots are occupied
        soc_cyc.delete();
        en = 0;
        wait_rdy();
        write_bytes(rnd_cell(), 53, 1);
        write_bytes(rnd_cell(), 53, 1);
        chk("rdy_both_full", wr_rdy, 0);
        c = rnd_cell();
        write_bytes(c, 53, 0);
        write_cell(c);
        drain();
        chk("b2b_cells", soc_cyc.size(), 3);
        if (soc_cyc.size() >= 2) chk("b2b_gap", soc_cyc[1] - soc_cyc[0], 53);

        // restart on wr_soc mid-fill: only the second cell goes out
        soc_cyc.delete();
        wait_rdy();
        write_bytes(rnd_cell(), 10, 0);
        write_cell(rnd_cell());
        drain();
        chk("restart_cells", soc_cyc.size(), 1);

        // reset during transmit of byte 30
        soc_cyc.delete();
        c = rnd_cell();
        write_cell(c);
        for (int n = 0; n < 100 && soc_cyc.size() == 0; n++) tick();
        chk("rst_tx_started", soc_cyc.size(), 1);
        repeat (28) tick();
        chk("byte30", data, c[29]);
        #3 rst = 1;
        #1;
        chk("mid_rst_data", data, 0);
        chk("mid_rst_soc", soc, 0);
        chk("mid_rst_clav", clav, 0);
        chk("mid_rst_rdy", wr_rdy, 1);
        exp_q.delete();
        tick();
        tick();
        rst = 0;
        repeat (80) tick();
        chk("post_rst_clav", clav, 0);
        write_cell(rnd_cell());
        drain();

        // reset during a write: leftover bytes without soc are not resumed
        wait_rdy();
        write_bytes(rnd_cell(), 20, 0);
        rst = 1;
        tick();
        rst = 0;
        wr_en = 1;
        wr_soc = 0;
        repeat (33) tick();
        wr_en = 0;
        repeat (60) tick();
        chk("partial_after_rst_clav", clav, 0);

        // randomized traffic with random en
        ren = 1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    wait_rdy();
                    p = rnd_cell();
                    write_bytes(p, $urandom_range(1, 52), 0);
                    write_cell(rnd_cell());
                end
                2: begin
                    wr_en = 1;
                    wr_soc = 0;
                    wr_data = 8'($urandom);
                    repeat ($urandom_range(1, 8)) tick();
                    wr_en = 0;
                end
                default: write_cell(rnd_cell());
            endcase
            repeat ($urandom_range(0, 30)) tick();
        end
        ren = 0;
        tick();
        drain();
        repeat (5) tick();
        chk("final_clav", clav, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
